dmux_rr_scheduler: RTL and testbench

//  Controller for the 1-to-4 demultiplexer. Accepts words from one upstream source over a

---
 rtl/dmux_rr_scheduler.sv | 157 +++++++++++++++
 tb/tb_dmux_rr_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmux_rr_scheduler.sv
// Round-robin controller for a 1-to-4 demux.
// Takes one word at a time from an upstream valid/ready source, picks a
// consumer round-robin among those that are enabled and ready, strobes it
// for one cycle, and drops the word if nobody is eligible for TIMEOUT
// consecutive arbitration cycles.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no word held; in_ready follows (en != 0)
//   ARB    | word latched; searching ptr, ptr+1, ... for an eligible consumer
//   SEND   | dst_valid/dmx_o presented to consumer sel for one cycle
module dmux_rr_scheduler #(
  parameter int DW      = 1,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  input  logic [3:0]       en,
  input  logic [3:0]       dst_ready,
  output logic [1:0]       sel,
  output logic [DW-1:0]    dmx_o,
  output logic [3:0]       dst_valid,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt
);

  // Wait counter only ever has to hold 0..TIMEOUT-1; keep at least one bit
  // so TIMEOUT=1 still elaborates.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         ptr;
  logic [1:0]         ptr_nxt;
  logic [1:0]         sel_nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [WAIT_W-1:0]  wait_nxt;
  logic [DW-1:0]      data_q;
  logic [DW-1:0]      data_nxt;
  logic [CNT_W-1:0]   drop_nxt;

  logic [3:0]         eligible;
  logic [7:0]         elig_dbl;
  logic [3:0]         elig_rot;
  logic               pick_ok;
  logic [1:0]         pick_ofs;
  logic [1:0]         pick;
  logic               accept;

  // Eligibility is re-evaluated every cycle from the live en/dst_ready.
  // Doubling the vector lets a plain part-select rotate it so that bit k
  // corresponds to consumer ptr+k (mod 4).
  assign eligible = en & dst_ready;
  assign elig_dbl = {eligible, eligible};
  assign elig_rot = elig_dbl[ptr +: 4];
  assign pick     = ptr + pick_ofs;

  // Lowest rotated offset wins, which is the first eligible consumer at or after ptr.
  always_comb begin
    pick_ok  = |elig_rot;
    pick_ofs = 2'd0;
    if (elig_rot[0])      pick_ofs = 2'd0;
    else if (elig_rot[1]) pick_ofs = 2'd1;
    else if (elig_rot[2]) pick_ofs = 2'd2;
    else                  pick_ofs = 2'd3;
  end

  // Moore-style outputs: everything except in_ready depends only on state,
  // so an async reset clears them without waiting for a clock edge.
  assign busy      = (state != S_IDLE);
  assign in_ready  = (state == S_IDLE) && (|en);
  assign accept    = in_valid && in_ready;
  assign dst_valid = (state == S_SEND) ? (4'b0001 << sel) : 4'b0000;
  assign dmx_o     = (state == S_SEND) ? data_q : '0;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= 2'd0;
      sel      <= 2'd0;
      wait_cnt <= '0;
      data_q   <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      sel      <= sel_nxt;
      wait_cnt <= wait_nxt;
      data_q   <= data_nxt;
      drop_cnt <= drop_nxt;
    end
  end

  // Next-state logic: accept, arbitrate with timeout, present and retire.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    wait_nxt  = wait_cnt;
    data_nxt  = data_q;
    drop_nxt  = drop_cnt;

    case (state)
      S_IDLE: begin
        if (accept) begin
          data_nxt  = in_data;
          wait_nxt  = '0;
          state_nxt = S_ARB;
        end
      end

      S_ARB: begin
        if (pick_ok) begin
          sel_nxt   = pick;
          state_nxt = S_SEND;
        end else if (wait_cnt == WAIT_LAST) begin
          // Word is abandoned; counter sticks at all-ones until reset.
          state_nxt = S_IDLE;
          if (drop_cnt != {CNT_W{1'b1}}) begin
            drop_nxt = drop_cnt + CNT_W'(1);
          end
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end

      S_SEND: begin
        if (dst_ready[sel]) begin
          // Advance fairness pointer past the consumer just served.
          ptr_nxt   = sel + 2'd1;
          state_nxt = S_IDLE;
        end else begin
          // Consumer backed off: keep ptr so the retry starts from the same place.
          wait_nxt  = '0;
          state_nxt = S_ARB;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmux_rr_scheduler.sv
// Self-checking bench for dmux_rr_scheduler: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_dmux_rr_scheduler;

  localparam int DW      = 8;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [DW-1:0]    in_data;
  logic             in_ready;
  logic [3:0]       en;
  logic [3:0]       dst_ready;
  logic [1:0]       sel;
  logic [DW-1:0]    dmx_o;
  logic [3:0]       dst_valid;
  logic             busy;
  logic [CNT_W-1:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: "is a word held", "is it being offered", target, fairness pointer.
  bit         m_have;
  bit         m_send;
  int         m_tgt;
  int         m_ptr;
  int         m_wait;
  int         m_drops;
  logic [7:0] m_word;

  logic       exp_busy;
  logic       exp_in_ready;
  logic [3:0] exp_dv;
  logic [7:0] exp_dmx;
  logic [1:0] exp_sel;
  logic [7:0] exp_drop;

  dmux_rr_scheduler #(.DW(DW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .en        (en),
    .dst_ready (dst_ready),
    .sel       (sel),
    .dmx_o     (dmx_o),
    .dst_valid (dst_valid),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_have  = 0;
    m_send  = 0;
    m_tgt   = 0;
    m_ptr   = 0;
    m_wait  = 0;
    m_drops = 0;
    m_word  = 8'h00;
  endtask

  // Drive one cycle of inputs at the falling edge, publish what the model
  // expects to see this cycle, then advance the model across the next rising edge.
  task automatic tick(input logic v, input logic [7:0] d, input logic [3:0] e, input logic [3:0] r);
    int found;
    int dd;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    en        = e;
    dst_ready = r;
    #1;
    exp_busy     = m_have;
    exp_in_ready = !m_have && (e != 4'b0000);
    exp_dv       = (m_have && m_send) ? (4'b0001 << m_tgt) : 4'b0000;
    exp_dmx      = (m_have && m_send) ? m_word : 8'h00;
    exp_sel      = 2'(m_tgt);
    exp_drop     = 8'(m_drops);

    if (!m_have) begin
      if (v && e != 4'b0000) begin
        m_have = 1;
        m_send = 0;
        m_word = d;
        m_wait = 0;
      end
    end else if (!m_send) begin
      found = -1;
      for (int k = 0; k < 4; k++) begin
        dd = (m_ptr + k) % 4;
        if (found < 0 && e[dd] && r[dd]) found = dd;
      end
      if (found >= 0) begin
        m_tgt  = found;
        m_send = 1;
      end else if (m_wait == TIMEOUT - 1) begin
        m_have = 0;
        if (m_drops < 255) m_drops++;
      end else begin
        m_wait++;
      end
    end else begin
      m_send = 0;
      if (r[m_tgt]) begin
        m_ptr  = (m_tgt + 1) % 4;
        m_have = 0;
      end else begin
        m_wait = 0;
      end
    end
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    en        = 4'b0000;
    dst_ready = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_dut();
    tick(1'b1, 8'h3C, 4'b1111, 4'b1111);
    tick(1'b0, 8'h00, 4'b0000, 4'b1111);
    #1 rst_n = 1'b0;
    en = 4'b0000;
    #1;
    checks++; if (in_ready !== 1'b0)      begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (busy !== 1'b0)          begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (sel !== 2'd0)           begin failures++; $display("FAIL reset_sel: got %0d expected 0", sel); end
    checks++; if (dst_valid !== 4'b0000)  begin failures++; $display("FAIL reset_dst_valid: got %b expected 0000", dst_valid); end
    checks++; if (dmx_o !== 8'h00)        begin failures++; $display("FAIL reset_dmx_o: got %h expected 00", dmx_o); end
    checks++; if (drop_cnt !== 8'h00)     begin failures++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_round_robin_all();
    logic [3:0] seq_dv [6];
    logic [1:0] seq_sel [6];
    int acc = 0;
    int n = 0;
    seq_dv  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    seq_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    reset_dut();
    for (int c = 0; c < 40 && n < 6; c++) begin
      tick(1'b1, 8'(8'hA0 + acc), 4'b1111, 4'b1111);
      if (in_ready) acc++;
      if (dst_valid != 4'b0000) begin
        checks++; if (dst_valid !== seq_dv[n]) begin failures++; $display("FAIL rr_all_dv[%0d]: got %b expected %b", n, dst_valid, seq_dv[n]); end
        checks++; if (sel !== seq_sel[n])      begin failures++; $display("FAIL rr_all_sel[%0d]: got %0d expected %0d", n, sel, seq_sel[n]); end
        checks++; if (dmx_o !== 8'(8'hA0 + n)) begin failures++; $display("FAIL rr_all_data[%0d]: got %h expected %h", n, dmx_o, 8'(8'hA0 + n)); end
        checks++; if (c != 2 + 3 * n)          begin failures++; $display("FAIL rr_all_cycle[%0d]: got %0d expected %0d", n, c, 2 + 3 * n); end
        n++;
      end
    end
    checks++; if (n != 6) begin failures++; $display("FAIL rr_all_count: got %0d strobes expected 6", n); end
  endtask

  task automatic test_skip_not_ready();
    logic [3:0] seq_dv [4];
    int n = 0;
    int bad = 0;
    seq_dv = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    reset_dut();
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick(1'b1, 8'(c), 4'b1111, 4'b0101);
      if ((dst_valid & 4'b1010) != 4'b0000) bad++;
      if (dst_valid != 4'b0000) begin
        checks++; if (dst_valid !== seq_dv[n]) begin failures++; $display("FAIL skip_dv[%0d]: got %b expected %b", n, dst_valid, seq_dv[n]); end
        n++;
      end
    end
    checks++; if (n != 4)   begin failures++; $display("FAIL skip_count: got %0d strobes expected 4", n); end
    checks++; if (bad != 0) begin failures++; $display("FAIL skip_strobe_1_3: got %0d strobes expected 0", bad); end
  endtask

  task automatic test_enable_gate();
    int got = 0;
    reset_dut();
    for (int c = 0; c < 3; c++) begin
      tick(1'b1, 8'h5A, 4'b0000, 4'b1111);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL gate_in_ready: got %b expected 0", in_ready); end
      checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL gate_busy: got %b expected 0", busy); end
    end
    for (int c = 0; c < 10 && got == 0; c++) begin
      tick(1'b1, 8'h5A, 4'b0010, 4'b1111);
      if (dst_valid != 4'b0000) begin
        got = 1;
        checks++; if (dst_valid !== 4'b0010) begin failures++; $display("FAIL gate_dv: got %b expected 0010", dst_valid); end
        checks++; if (dmx_o !== 8'h5A)       begin failures++; $display("FAIL gate_data: got %h expected 5a", dmx_o); end
      end
    end
    checks++; if (got != 1) begin failures++; $display("FAIL gate_delivery: got %0d expected 1", got); end
  endtask

  task automatic test_timeout_drop();
    int busy_cycles = 0;
    int strobes = 0;
    int done = 0;
    reset_dut();
    tick(1'b1, 8'h77, 4'b0001, 4'b0000);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL to_accept: got %b expected 1", in_ready); end
    for (int c = 0; c < 20 && done == 0; c++) begin
      tick(1'b0, 8'h00, 4'b0001, 4'b0000);
      if (dst_valid != 4'b0000) strobes++;
      if (busy) begin
        busy_cycles++;
        checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL to_early_drop: got %0d expected 0", drop_cnt); end
      end else begin
        done = 1;
      end
    end
    checks++; if (busy_cycles != TIMEOUT) begin failures++; $display("FAIL to_busy_cycles: got %0d expected %0d", busy_cycles, TIMEOUT); end
    checks++; if (drop_cnt !== 8'd1)      begin failures++; $display("FAIL to_drop_cnt: got %0d expected 1", drop_cnt); end
    checks++; if (strobes != 0)           begin failures++; $display("FAIL to_strobes: got %0d expected 0", strobes); end
  endtask

  task automatic test_send_backoff();
    logic       vs [10];
    logic [3:0] rs [10];
    logic [3:0] dvs [10];
    vs  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rs  = '{4'hF, 4'hF, 4'hE, 4'hF, 4'hF, 4'hF, 4'hF, 4'hD, 4'hD, 4'hF};
    dvs = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h4};
    reset_dut();
    for (int c = 0; c < 10; c++) begin
      tick(vs[c], 8'(8'h10 + c), 4'b1111, rs[c]);
      checks++; if (dst_valid !== dvs[c]) begin failures++; $display("FAIL backoff_dv[%0d]: got %b expected %b", c, dst_valid, dvs[c]); end
    end
    checks++; if (sel !== 2'd2)      begin failures++; $display("FAIL backoff_sel: got %0d expected 2", sel); end
    checks++; if (dmx_o !== 8'h15)   begin failures++; $display("FAIL backoff_data: got %h expected 15", dmx_o); end
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL backoff_drop: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_async_reset();
    int got = 0;
    reset_dut();
    tick(1'b1, 8'h11, 4'b0001, 4'b0000);
    for (int c = 0; c < TIMEOUT + 1; c++) tick(1'b0, 8'h00, 4'b0001, 4'b0000);
    checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL ar_pre_drop: got %0d expected 1", drop_cnt); end
    tick(1'b1, 8'h55, 4'b1111, 4'b1111);
    tick(1'b0, 8'h00, 4'b1111, 4'b1111);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ar_in_arb: got %b expected 1", busy); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL ar_arb_busy: got %b expected 0", busy); end
    checks++; if (drop_cnt !== 8'd0)  begin failures++; $display("FAIL ar_arb_drop: got %0d expected 0", drop_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) tick(c == 0, 8'h21, 4'b1111, 4'b1111);
    tick(1'b1, 8'h22, 4'b1111, 4'b1111);
    tick(1'b0, 8'h00, 4'b1111, 4'b1111);
    tick(1'b0, 8'h00, 4'b1111, 4'b1111);
    checks++; if (dst_valid !== 4'b0010) begin failures++; $display("FAIL ar_in_send: got %b expected 0010", dst_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (dst_valid !== 4'b0000) begin failures++; $display("FAIL ar_send_dv: got %b expected 0000", dst_valid); end
    checks++; if (sel !== 2'd0)          begin failures++; $display("FAIL ar_send_sel: got %0d expected 0", sel); end
    checks++; if (dmx_o !== 8'h00)       begin failures++; $display("FAIL ar_send_dmx: got %h expected 00", dmx_o); end
    checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL ar_send_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 10 && got == 0; c++) begin
      tick(c == 0, 8'h99, 4'b1111, 4'b1111);
      if (dst_valid != 4'b0000) begin
        got = 1;
        checks++; if (dst_valid !== 4'b0001) begin failures++; $display("FAIL ar_first_dv: got %b expected 0001", dst_valid); end
      end
    end
    checks++; if (got != 1) begin failures++; $display("FAIL ar_first_delivery: got %0d expected 1", got); end
  endtask

  task automatic test_drop_saturation();
    int bad = 0;
    reset_dut();
    for (int c = 0; c < 265 * (TIMEOUT + 1) && bad == 0; c++) begin
      tick(1'b1, 8'hEE, 4'b0001, 4'b0000);
      checks++;
      if (drop_cnt !== exp_drop) begin
        failures++; bad = 1;
        $display("FAIL sat_track[%0d]: got %0d expected %0d", c, drop_cnt, exp_drop);
      end
    end
    checks++; if (drop_cnt !== 8'hFF) begin failures++; $display("FAIL sat_final: got %0d expected 255", drop_cnt); end
  endtask

  task automatic test_random();
    logic [3:0] e = 4'hF;
    logic [3:0] r;
    logic       v;
    int bad = 0;
    reset_dut();
    for (int c = 0; c < 1500 && bad == 0; c++) begin
      if ($urandom_range(0, 7) == 0) e = 4'($urandom_range(0, 15));
      r = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      v = ($urandom_range(0, 9) < 7);
      tick(v, 8'($urandom), e, r);
      checks++;
      if (busy !== exp_busy || in_ready !== exp_in_ready || dst_valid !== exp_dv ||
          dmx_o !== exp_dmx || sel !== exp_sel || drop_cnt !== exp_drop) begin
        failures++; bad = 1;
        $display("FAIL random[%0d]: got busy=%b rdy=%b dv=%b dmx=%h sel=%0d drop=%0d expected busy=%b rdy=%b dv=%b dmx=%h sel=%0d drop=%0d",
                 c, busy, in_ready, dst_valid, dmx_o, sel, drop_cnt,
                 exp_busy, exp_in_ready, exp_dv, exp_dmx, exp_sel, exp_drop);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    en        = 4'b0000;
    dst_ready = 4'b0000;
    model_reset();
    test_reset();
    test_round_robin_all();
    test_skip_not_ready();
    test_enable_gate();
    test_timeout_drop();
    test_send_backoff();
    test_async_reset();
    test_drop_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
